// File: rtl/pbus_capture.sv
// pbus_capture: receive-side capture stage for the parallel address/data
// test bus. Registers the bus pins, tracks bursts (contiguous runs of
// oe-high beats), buffers every beat as {first, addr, data} in a
// first-word-fall-through FIFO and keeps address-sequence, burst and
// overflow statistics for the downstream checker.
module pbus_capture #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_data,
  input  logic              bus_oe,
  input  logic              clr,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_first,
  output logic              fifo_full,
  output logic              overflow,
  output logic [15:0]       seq_err_cnt,
  output logic [15:0]       burst_cnt,
  output logic [ADDR_W:0]   last_len
);

  // Stored word layout: {first, addr, data}
  localparam int WORD_W = ADDR_W + DATA_W + 1;
  localparam int DEPTH  = 1 << FIFO_AW;

  localparam logic [ADDR_W:0]  LEN_MAX  = '1;
  localparam logic [ADDR_W:0]  LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [15:0]      CNT_MAX  = 16'hFFFF;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Input stage
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              oe_q;

  // Burst tracking
  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] expected_reg;
  logic [ADDR_W:0]   len_reg;

  // Per-cycle decisions from the FSM output logic
  logic push_req;
  logic push_first;
  logic seq_mismatch;
  logic burst_end;

  // FIFO storage and bookkeeping
  logic [WORD_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_reg;
  logic [FIFO_AW-1:0] rd_ptr_reg;
  logic [FIFO_AW:0]   count_reg;
  logic [WORD_W-1:0]  head_word;
  logic               pop;
  logic               push_ok;
  logic               push_drop;

  // Statistics
  logic              overflow_reg;
  logic [15:0]       seq_err_cnt_reg;
  logic [15:0]       burst_cnt_reg;
  logic [ADDR_W:0]   last_len_reg;

  // Sample the bus pins; every decision below looks only at these copies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
      oe_q   <= 1'b0;
    end else begin
      addr_q <= bus_addr;
      data_q <= bus_data;
      oe_q   <= bus_oe;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state: a burst lasts exactly as long as oe_q stays high
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (oe_q)  state_next = BURST;
      BURST:   if (!oe_q) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: classify the sampled beat as first, continuation or burst end
  always_comb begin
    push_req     = 1'b0;
    push_first   = 1'b0;
    seq_mismatch = 1'b0;
    burst_end    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (oe_q) begin
          push_req   = 1'b1;
          push_first = 1'b1;
        end
      end
      BURST: begin
        if (oe_q) begin
          push_req     = 1'b1;
          seq_mismatch = (addr_q != expected_reg);
        end else begin
          burst_end = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Expected next address and running length; the expected address always
  // follows the last seen address so one bad beat costs only one error, and
  // dropped beats still advance both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expected_reg <= '0;
      len_reg      <= '0;
    end else if (push_req) begin
      expected_reg <= addr_q + 1'b1;
      if (push_first) begin
        len_reg <= LEN_ONE;
      end else if (len_reg != LEN_MAX) begin
        len_reg <= len_reg + 1'b1;
      end
    end
  end

  // Push/pop arbitration: a full FIFO still accepts when the head leaves
  // in the same cycle
  assign pop       = out_valid && out_ready;
  assign push_ok   = push_req && (!fifo_full || pop);
  assign push_drop = push_req && fifo_full && !pop;

  // FIFO storage write; the array carries no reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= {push_first, addr_q, data_q};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head of FIFO, forced to zero while empty so stale RAM never shows
  always_comb begin
    head_word = mem[rd_ptr_reg];
    out_valid = (count_reg != '0);
    fifo_full = (count_reg == FULL_CNT);
    if (out_valid) begin
      out_first = head_word[WORD_W-1];
      out_addr  = head_word[ADDR_W+DATA_W-1:DATA_W];
      out_data  = head_word[DATA_W-1:0];
    end else begin
      out_first = 1'b0;
      out_addr  = '0;
      out_data  = '0;
    end
  end

  // Sticky overflow flag; clr has priority over a same-cycle drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg <= 1'b0;
    end else if (clr) begin
      overflow_reg <= 1'b0;
    end else if (push_drop) begin
      overflow_reg <= 1'b1;
    end
  end

  // Saturating address-sequence error counter; clr has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_err_cnt_reg <= '0;
    end else if (clr) begin
      seq_err_cnt_reg <= '0;
    end else if (seq_mismatch && (seq_err_cnt_reg != CNT_MAX)) begin
      seq_err_cnt_reg <= seq_err_cnt_reg + 1'b1;
    end
  end

  // Wrapping completed-burst counter; clr has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_reg <= '0;
    end else if (clr) begin
      burst_cnt_reg <= '0;
    end else if (burst_end) begin
      burst_cnt_reg <= burst_cnt_reg + 1'b1;
    end
  end

  // Length of the last completed burst; unaffected by clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_len_reg <= '0;
    end else if (burst_end) begin
      last_len_reg <= len_reg;
    end
  end

  assign overflow    = overflow_reg;
  assign seq_err_cnt = seq_err_cnt_reg;
  assign burst_cnt   = burst_cnt_reg;
  assign last_len    = last_len_reg;

endmodule
